// File: rtl/uart_pkg.sv
// Shared UART constants: bit-timing helpers, receiver state encoding and
// the framing characters the message layer looks for.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int TICK_W = 9;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_DASH = 8'h2D;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(input int clk_freq, input int baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs; flops reset to a
// configurable value (idle-high by default for serial lines).
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised line, one-cycle
// strobes for a good byte or a framing error.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_msg,
  output logic       rx_complete,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF_BIT - 1);

  logic              rx_s;
  rx_state_t         state, state_nxt;
  logic [TICK_W-1:0] tick;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;

  logic at_half, at_last;
  logic tick_clr, tick_inc, bit_clr, shift_en, load_msg, err_pulse;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk_50M),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign at_half = (tick == TICK_HALF);
  assign at_last = (tick == TICK_LAST);

  always_ff @(posedge clk_50M) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!rx_s) state_nxt = ST_START;
      ST_START: if (at_half) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (at_last && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP:  if (at_last) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
      // A held-low line must return high before another start is accepted.
      ST_BREAK: if (rx_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tick_clr  = 1'b0;
    tick_inc  = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    load_msg  = 1'b0;
    err_pulse = 1'b0;
    case (state)
      ST_IDLE:  tick_clr = 1'b1;
      ST_START: begin
        if (at_half) begin
          tick_clr = 1'b1;
          bit_clr  = 1'b1;
        end else begin
          tick_inc = 1'b1;
        end
      end
      ST_DATA: begin
        if (at_last) begin
          shift_en = 1'b1;
          tick_clr = 1'b1;
        end else begin
          tick_inc = 1'b1;
        end
      end
      ST_STOP: begin
        if (at_last) begin
          tick_clr  = 1'b1;
          load_msg  = rx_s;
          err_pulse = !rx_s;
        end else begin
          tick_inc = 1'b1;
        end
      end
      ST_BREAK: tick_clr = 1'b1;
      default:  tick_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      tick        <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_msg      <= 8'h00;
      rx_complete <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (tick_clr)      tick <= '0;
      else if (tick_inc) tick <= tick + 1'b1;

      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;

      // LSB arrives first, so each new bit enters at the top.
      if (shift_en) shreg <= {rx_s, shreg[7:1]};

      if (load_msg) rx_msg <= shreg;
      rx_complete <= load_msg;
      frame_err   <= err_pulse;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 32 clocks per bit: latency, back-to-back
// frames, glitch rejection, framing error, mid-frame reset, baud tolerance.
module tb_uart_rx_byte;

  localparam int CLK_FREQ = 3_686_400;
  localparam int BAUD     = 115200;
  localparam int CPB      = 32;
  localparam int HALF     = 16;
  localparam int CLK_P    = 10;
  localparam int BIT_T    = CPB * CLK_P;
  localparam int LAT_NOM  = 2 + 1 + HALF + 9 * CPB;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_err = 0;
  int strobe_cyc = 0;
  logic [7:0] got_q[$];
  logic prev_rc = 1'b0;
  logic prev_fe = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         pct;
    int         exp_cnt;
    int         exp_err;
    logic [7:0] exp_msg;
  } vec_t;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .rx          (rx),
    .rx_msg      (rx_msg),
    .rx_complete (rx_complete),
    .frame_err   (frame_err)
  );

  always #(CLK_P / 2) clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  always @(negedge clk_50M) begin
    if (rx_complete) begin
      got_q.push_back(rx_msg);
      strobe_cyc = cyc;
      total++;
      if (frame_err || prev_rc) begin
        bad++;
        $display("FAIL strobe_shape: rx_complete=%0b frame_err=%0b prev_rx_complete=%0b at cycle %0d, required single-cycle exclusive strobe",
                 rx_complete, frame_err, prev_rc, cyc);
      end
    end
    if (frame_err) begin
      n_err++;
      total++;
      if (prev_fe) begin
        bad++;
        $display("FAIL err_width: frame_err high two cycles at cycle %0d, required one cycle", cyc);
      end
    end
    prev_rc = rx_complete;
    prev_fe = frame_err;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_t);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_t);
    end
    rx = stop;
    #(bit_t);
  endtask

  initial begin
    vec_t vecs[8];
    logic [7:0] msg[7];
    int n0, e0, start_cyc, lat;

    vecs[0] = '{8'h00, 1'b1, 102, 1, 0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 102, 1, 0, 8'hFF};
    vecs[2] = '{8'hAA, 1'b1, 102, 1, 0, 8'hAA};
    vecs[3] = '{8'h00, 1'b1,  98, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1,  98, 1, 0, 8'hFF};
    vecs[5] = '{8'hAA, 1'b1,  98, 1, 0, 8'hAA};
    vecs[6] = '{8'hC3, 1'b0, 100, 0, 1, 8'hAA};
    vecs[7] = '{8'h7E, 1'b1, 100, 1, 0, 8'h7E};
    msg = '{8'h49, 8'h46, 8'h4D, 8'h2D, 8'h45, 8'h2D, 8'h23};

    repeat (4) @(negedge clk_50M);
    check("reset_rx_msg", int'(rx_msg), 0);
    check("reset_rx_complete", int'(rx_complete), 0);
    check("reset_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_50M);

    // Single byte with latency measured from the first edge that sees low.
    n0 = got_q.size();
    e0 = n_err;
    start_cyc = cyc;
    send_frame(8'h23, 1'b1, BIT_T);
    #(BIT_T);
    check("hash_count", got_q.size() - n0, 1);
    check("hash_data", int'(rx_msg), 8'h23);
    check("hash_no_err", n_err - e0, 0);
    lat = strobe_cyc - (start_cyc + 1);
    total++;
    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
      bad++;
      $display("FAIL latency: got %0d cycles required %0d +/-1", lat, LAT_NOM);
    end

    // Seven frames with zero idle between them.
    n0 = got_q.size();
    for (int i = 0; i < 7; i++) send_frame(msg[i], 1'b1, BIT_T);
    #(2 * BIT_T);
    check("b2b_count", got_q.size() - n0, 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("b2b_byte%0d", i), (n0 + i < got_q.size()) ? int'(got_q[n0 + i]) : -1, int'(msg[i]));

    // Short low glitch must not start a frame.
    n0 = got_q.size();
    e0 = n_err;
    @(negedge clk_50M);
    rx = 1'b0;
    #(8 * CLK_P);
    rx = 1'b1;
    #(3 * BIT_T);
    check("glitch_no_strobe", got_q.size() - n0, 0);
    check("glitch_no_err", n_err - e0, 0);
    send_frame(8'h55, 1'b1, BIT_T);
    #(BIT_T);
    check("after_glitch_count", got_q.size() - n0, 1);
    check("after_glitch_data", int'(rx_msg), 8'h55);

    // Stop bit low, line held low, then released.
    n0 = got_q.size();
    e0 = n_err;
    send_frame(8'hA5, 1'b0, BIT_T);
    #(2000 * CLK_P);
    rx = 1'b1;
    #(2 * BIT_T);
    check("ferr_pulse", n_err - e0, 1);
    check("ferr_no_strobe", got_q.size() - n0, 0);
    check("ferr_msg_held", int'(rx_msg), 8'h55);
    send_frame(8'h3C, 1'b1, BIT_T);
    #(BIT_T);
    check("after_ferr_count", got_q.size() - n0, 1);
    check("after_ferr_data", int'(rx_msg), 8'h3C);

    // Reset pulse during bit 4 of 8'hFF.
    n0 = got_q.size();
    e0 = n_err;
    rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      #(BIT_T);
    end
    rx = 1'b1;
    #(BIT_T / 2);
    @(negedge clk_50M);
    rst = 1'b1;
    @(negedge clk_50M);
    rst = 1'b0;
    #(6 * BIT_T);
    check("rst_no_strobe", got_q.size() - n0, 0);
    check("rst_no_err", n_err - e0, 0);
    check("rst_msg_cleared", int'(rx_msg), 0);
    send_frame(8'h0F, 1'b1, BIT_T);
    #(BIT_T);
    check("after_rst_count", got_q.size() - n0, 1);
    check("after_rst_data", int'(rx_msg), 8'h0F);

    // Table: baud tolerance and a bad-stop row.
    for (int v = 0; v < 8; v++) begin
      n0 = got_q.size();
      e0 = n_err;
      send_frame(vecs[v].data, vecs[v].stop, (BIT_T * 100) / vecs[v].pct);
      rx = 1'b1;
      #(2 * BIT_T);
      check($sformatf("vec%0d_count", v), got_q.size() - n0, vecs[v].exp_cnt);
      check($sformatf("vec%0d_err", v), n_err - e0, vecs[v].exp_err);
      check($sformatf("vec%0d_msg", v), int'(rx_msg), int'(vecs[v].exp_msg));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
